// File: rtl/grant_rr_wgt.sv
// grant_rr_wgt: weighted round-robin arbiter with per-requester burst quotas and lock
module grant_rr_wgt #(
  parameter int REQ_NUM = 4,
  parameter int CNT_W   = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REQ_NUM-1:0]       req_bits,
  input  logic [REQ_NUM*CNT_W-1:0] weight_cfg,
  input  logic                     get,
  input  logic                     lock,
  output logic [REQ_NUM-1:0]       grant_bits,
  output logic                     grant_valid,
  output logic [ID_W-1:0]          grant_id
);
  typedef enum logic {IDLE, GRANT} st_t;
  st_t st_q, st_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, start, win, nxt;
  logic [CNT_W-1:0] cr_q, cr_d, wt;
  logic [REQ_NUM-1:0] gnt_q, gnt_d;
  logic vld_q, vld_d, any, dec, arb;

  function automatic logic [ID_W-1:0] pick(input logic [REQ_NUM-1:0] r, input logic [ID_W-1:0] s);
    logic [2*REQ_NUM-1:0] rot;
    rot = {r, r} >> s;
    pick = s;
    for (int k = REQ_NUM - 1; k >= 0; k--)
      if (rot[k]) pick = ID_W'((int'(s) + k) % REQ_NUM);
  endfunction

  assign any   = |req_bits;
  assign nxt   = (id_q == ID_W'(REQ_NUM - 1)) ? '0 : id_q + 1'b1;
  assign dec   = (st_q == GRANT) && !lock && get && (cr_q > CNT_W'(1)) && req_bits[id_q];
  // a burst ends on the last credit or when the owner drops its request
  assign arb   = (st_q == IDLE) ? any : (!lock && !dec && (get || !req_bits[id_q]));
  assign start = (st_q == IDLE) ? ptr_q : (get ? nxt : id_q);
  assign win   = pick(req_bits, start);
  assign wt    = weight_cfg[win*CNT_W +: CNT_W];

  always_comb begin
    ptr_d = (arb && st_q == GRANT) ? start : ptr_q;
    st_d  = arb ? (any ? GRANT : IDLE) : st_q;
    id_d  = arb ? (any ? win : '0) : id_q;
    vld_d = arb ? any : vld_q;
    gnt_d = arb ? (any ? (REQ_NUM'(1) << win) : '0) : gnt_q;
    cr_d  = arb ? (any ? ((wt == '0) ? CNT_W'(1) : wt) : '0) : (dec ? cr_q - 1'b1 : cr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      ptr_q <= '0;
      id_q  <= '0;
      cr_q  <= '0;
      gnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      ptr_q <= ptr_d;
      id_q  <= id_d;
      cr_q  <= cr_d;
      gnt_q <= gnt_d;
      vld_q <= vld_d;
    end
  end

  assign grant_bits  = gnt_q;
  assign grant_valid = vld_q;
  assign grant_id    = id_q;
endmodule
